// File: rtl/chimera_cluster_isolate.sv
// chimera_cluster_isolate
// Cycle-transparent AXI guard for one cluster master port. Tracks outstanding
// reads and writes, caps each direction at MaxOutstanding, and on request
// quiesces the port (block new AW/AR, drain in-flight traffic, then report
// isolation) so the cluster can be clock-gated or reset safely.
// The default request/response types are minimal stand-ins; the parent
// supplies the real AXI structs. Only the fields named here are used:
// aw_valid, ar_valid, w_valid, w.last, b_ready, r_ready, and the matching
// ready/valid fields plus r.last on the response side.
module chimera_cluster_isolate #(
  parameter int unsigned MaxOutstanding = 16,
  parameter type axi_req_t = struct packed {
    logic [31:0] aw;
    logic        aw_valid;
    struct packed {
      logic [31:0] data;
      logic        last;
    } w;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar;
    logic        ar_valid;
    logic        r_ready;
  },
  parameter type axi_resp_t = struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic [5:0]  b;
    logic        b_valid;
    struct packed {
      logic [31:0] data;
      logic        last;
    } r;
    logic        r_valid;
  },
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            isolate_i,
  output logic            isolated_o,
  input  axi_req_t        slv_req_i,
  output axi_resp_t       slv_resp_o,
  output axi_req_t        mst_req_o,
  input  axi_resp_t       mst_resp_i,
  output logic [CntW-1:0] wr_outstanding_o,
  output logic [CntW-1:0] rd_outstanding_o
);

  // Pending-W tracker is signed: W data may legally run ahead of its AW.
  localparam int unsigned PendW = CntW + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic signed [PendW-1:0] MaxPend = PendW'(MaxOutstanding);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ISOLATED = 2'd2
  } state_e;

  state_e                   r_state;
  state_e                   w_state_next;
  logic [CntW-1:0]          r_wr_cnt;
  logic [CntW-1:0]          r_rd_cnt;
  logic signed [PendW-1:0]  r_w_pend;
  logic                     r_aw_sticky;
  logic                     r_ar_sticky;

  logic w_aw_open;
  logic w_ar_open;
  logic w_w_open;
  logic w_mst_aw_valid;
  logic w_mst_ar_valid;
  logic w_mst_w_valid;
  logic w_aw_hs;
  logic w_ar_hs;
  logic w_wlast_hs;
  logic w_b_hs;
  logic w_rlast_hs;
  logic w_drained;

  // Gates depend only on registered state, so no ready-to-valid path exists.
  // A sticky flag keeps an already presented AW/AR open until it handshakes.
  assign w_aw_open = ((r_state == ST_RUN) && (r_wr_cnt < MaxCnt)) || r_aw_sticky;
  assign w_ar_open = ((r_state == ST_RUN) && (r_rd_cnt < MaxCnt)) || r_ar_sticky;
  assign w_w_open  = (r_state != ST_ISOLATED);

  assign w_mst_aw_valid = slv_req_i.aw_valid & w_aw_open;
  assign w_mst_ar_valid = slv_req_i.ar_valid & w_ar_open;
  assign w_mst_w_valid  = slv_req_i.w_valid & w_w_open;

  assign w_aw_hs    = w_mst_aw_valid & mst_resp_i.aw_ready;
  assign w_ar_hs    = w_mst_ar_valid & mst_resp_i.ar_ready;
  assign w_wlast_hs = w_mst_w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
  assign w_b_hs     = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign w_rlast_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

  assign w_drained = (r_wr_cnt == '0) && (r_rd_cnt == '0) && (r_w_pend == '0)
                   && !r_aw_sticky && !r_ar_sticky;

  // Payload passes straight through; only AW/AR/W valid and ready are gated.
  always_comb begin
    mst_req_o           = slv_req_i;
    slv_resp_o          = mst_resp_i;
    mst_req_o.aw_valid  = w_mst_aw_valid;
    mst_req_o.ar_valid  = w_mst_ar_valid;
    mst_req_o.w_valid   = w_mst_w_valid;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_aw_open;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_ar_open;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & w_w_open;
  end

  // Next-state logic for the quiesce sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (isolate_i) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!isolate_i)     w_state_next = ST_RUN;
        else if (w_drained) w_state_next = ST_ISOLATED;
      end
      ST_ISOLATED: begin
        if (!isolate_i) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // State register, outstanding counters and valid-stability flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_RUN;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_w_pend    <= '0;
      r_aw_sticky <= 1'b0;
      r_ar_sticky <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      // Simultaneous increment and decrement cancel out.
      r_wr_cnt    <= r_wr_cnt + CntW'(w_aw_hs) - CntW'(w_b_hs);
      r_rd_cnt    <= r_rd_cnt + CntW'(w_ar_hs) - CntW'(w_rlast_hs);
      r_w_pend    <= r_w_pend + PendW'(w_aw_hs) - PendW'(w_wlast_hs);
      // Set while a forwarded valid waits for ready, cleared on handshake.
      r_aw_sticky <= w_mst_aw_valid & ~mst_resp_i.aw_ready;
      r_ar_sticky <= w_mst_ar_valid & ~mst_resp_i.ar_ready;
    end
  end

  assign isolated_o       = (r_state == ST_ISOLATED);
  assign wr_outstanding_o = r_wr_cnt;
  assign rd_outstanding_o = r_rd_cnt;

  // Counters never wrap; a wrap means the surrounding protocol is broken.
  a_wr_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_aw_hs && !w_b_hs && (r_wr_cnt == MaxCnt)));
  a_wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_b_hs && !w_aw_hs && (r_wr_cnt == '0)));
  a_rd_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_ar_hs && !w_rlast_hs && (r_rd_cnt == MaxCnt)));
  a_rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_rlast_hs && !w_ar_hs && (r_rd_cnt == '0)));
  a_wp_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_aw_hs && !w_wlast_hs && (r_w_pend == MaxPend)));
  a_wp_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_wlast_hs && !w_aw_hs && (r_w_pend == -MaxPend)));

endmodule
